// File: rtl/spi_midi_tx.sv
// spi_midi_tx: SPI mode-0 master that shifts out 3-byte MIDI messages MSB-first.
// A message is taken over a valid/ready handshake. Each byte is sent as 8 bits.
// Each bit has a low phase and a high phase of CLK_DIV cycles each.
// Between bytes of one message, sclk is held low for BYTE_GAP cycles.
// There is no chip-select: the receiver frames by counting bytes.
// Every output is driven straight from a flop.
module spi_midi_tx #(
   parameter int CLK_DIV  = 4,
   parameter int BYTE_GAP = 8,
   parameter int CNT_W    = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_b,
   input  logic [23:0] i_msg,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_spi_sclk,
   output logic        o_spi_mosi,
   output logic        o_busy,
   output logic        o_done,
   output logic [1:0]  o_byte_counter
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   // Terminal counts for the shared divider / gap counter.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = (BYTE_GAP > 0) ? CNT_W'(BYTE_GAP - 1) : '0;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   // Holds the bits that remain after the one currently on mosi.
   logic [22:0]      shreg;

   logic accept;
   logic half_end;
   logic gap_end;
   logic bit_end;
   logic byte_end;
   logic msg_end;

   // Decode of phase and frame boundaries, shared by every register block below.
   // NOTE: each signal gets a default value first in always_comb. Then no path
   //       leaves a signal unassigned, and so no latch is inferred.
   always_comb begin
      accept   = 1'b0;
      half_end = 1'b0;
      gap_end  = 1'b0;
      bit_end  = 1'b0;
      byte_end = 1'b0;
      msg_end  = 1'b0;
      accept   = (state == ST_IDLE) && i_valid;
      half_end = (cnt == HALF_LAST);
      gap_end  = (cnt == GAP_LAST);
      bit_end  = (state == ST_HIGH) && half_end;
      byte_end = bit_end && (bit_cnt == 3'd7);
      msg_end  = byte_end && (o_byte_counter == 2'd2);
   end

   // Phase sequencer: IDLE -> (LOW -> HIGH) x 8 -> GAP -> ... -> IDLE.
   // NOTE: sequential state uses non-blocking assignments only. Then every
   //       flop samples its inputs from before the edge, whatever order the blocks run in.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (accept) begin
                  state <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (half_end) begin
                  cnt   <= '0;
                  state <= ST_HIGH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HIGH: begin
               if (half_end) begin
                  cnt <= '0;
                  if (msg_end) begin
                     state <= ST_IDLE;
                  end else if (byte_end && (BYTE_GAP > 0)) begin
                     state <= ST_GAP;
                  end else begin
                     state <= ST_LOW;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_end) begin
                  cnt   <= '0;
                  state <= ST_LOW;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Serializer: load on accept, shift at the end of each high phase, park mosi low when done.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         o_spi_mosi <= 1'b0;
      end else if (accept) begin
         shreg      <= i_msg[22:0];
         bit_cnt    <= '0;
         o_spi_mosi <= i_msg[23];
      end else if (msg_end) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         o_spi_mosi <= 1'b0;
      end else if (bit_end) begin
         // The next bit goes onto mosi on the same edge that sclk falls.
         o_spi_mosi <= shreg[22];
         shreg      <= {shreg[21:0], 1'b0};
         bit_cnt    <= bit_cnt + 3'd1;
      end
   end

   // SPI clock: rises when a low phase ends and falls when a high phase ends. It idles low.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         o_spi_sclk <= 1'b0;
      end else if ((state == ST_LOW) && half_end) begin
         o_spi_sclk <= 1'b1;
      end else if (bit_end) begin
         o_spi_sclk <= 1'b0;
      end
   end

   // Byte index: steps after bit 7 of bytes 0 and 1, and returns to 0 with the last byte.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         o_byte_counter <= 2'd0;
      end else if (accept || msg_end) begin
         o_byte_counter <= 2'd0;
      end else if (byte_end) begin
         o_byte_counter <= o_byte_counter + 2'd1;
      end
   end

   // Handshake and status flags. ready comes back in the same cycle as done,
   // so a message can be accepted back-to-back.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         o_ready <= 1'b1;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         o_done <= msg_end;
         if (accept) begin
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
         end else if (msg_end) begin
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
         end
      end
   end

endmodule
